// File: rtl/hollywood_hash_search_core.sv
// Hollywood hash candidate search core.
// Password data words are streamed into a two-register hash (r4, r6). A command
// beat either clears the candidate or evaluates it against the target pair
// (R4, R6). An evaluate either reports a result on the output handshake or
// silently advances to the next candidate.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   in_valid/ready   input handshake; in_channel 0 = data word, 1 = command
//   in_data          data word, or command (bit0: 0 clear, 1 evaluate)
//   out_valid/ready  result handshake
//   out_match        candidate hash hit the target within the length limit
//   out_length       words in the candidate, saturating at MAX_WORDS+1
//   out_index        zero-based candidate index
//   match_count      matches transferred since reset, saturating
module hollywood_hash_search_core #(
    parameter int unsigned       WIDTH      = 16,
    parameter logic [WIDTH-1:0]  R4         = WIDTH'(16'hFEB1),
    parameter logic [WIDTH-1:0]  R6         = WIDTH'(16'h9298),
    parameter int unsigned       MAX_WORDS  = 8,
    parameter bit                REPORT_ALL = 1'b0,
    localparam int unsigned      LW         = $clog2(MAX_WORDS + 2)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_channel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_match,
    output logic [LW-1:0]    out_length,
    output logic [31:0]      out_index,
    output logic [15:0]      match_count
);

    localparam logic [LW-1:0] LEN_SAT = LW'(MAX_WORDS + 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_WORDS);

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] r4;
    logic [WIDTH-1:0] r6;
    logic [LW-1:0]    len;
    logic [31:0]      cand_idx;

    // Swap the two halves of a hash word.
    function automatic logic [WIDTH-1:0] sw(input logic [WIDTH-1:0] x);
        return {x[WIDTH/2-1:0], x[WIDTH-1:WIDTH/2]};
    endfunction

    logic [WIDTH-1:0] data_sw;
    logic             hit;
    logic             accept;

    assign data_sw = sw(in_data);
    assign hit     = (r4 == R4) && (r6 == R6) && (len <= LEN_MAX);
    assign accept  = in_valid && in_ready;

    // Hash accumulation, command handling and result handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ACCUM;
            in_ready    <= 1'b0;
            r4          <= '0;
            r6          <= '0;
            len         <= '0;
            cand_idx    <= '0;
            out_valid   <= 1'b0;
            out_match   <= 1'b0;
            out_length  <= '0;
            out_index   <= '0;
            match_count <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (!in_channel) begin
                            r4 <= r6 ^ data_sw;
                            r6 <= sw(r4 + data_sw);
                            if (len != LEN_SAT) begin
                                len <= len + LW'(1);
                            end
                        end else begin
                            // Both clear and evaluate start a fresh candidate.
                            r4  <= '0;
                            r6  <= '0;
                            len <= '0;
                            if (in_data[0]) begin
                                cand_idx <= cand_idx + 32'd1;
                                if (hit || REPORT_ALL) begin
                                    out_match  <= hit;
                                    out_length <= len;
                                    out_index  <= cand_idx;
                                    out_valid  <= 1'b1;
                                    in_ready   <= 1'b0;
                                    state      <= REPORT;
                                end
                            end
                        end
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACCUM;
                        if (out_match && (match_count != 16'hFFFF)) begin
                            match_count <= match_count + 16'd1;
                        end
                    end
                end
                default: begin
                    state     <= ACCUM;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hollywood_hash_search_core.sv
// Bench for hollywood_hash_search_core: two instances (A reports every
// candidate with a 2-word limit, B reports matches only with an 8-word limit),
// directed scenarios plus random streams checked against a behavioural model.
module tb_hollywood_hash_search_core;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A signals
    logic        a_in_valid = 1'b0, a_in_channel = 1'b0, a_out_ready = 1'b0;
    logic [15:0] a_in_data = '0;
    logic        a_in_ready, a_out_valid, a_out_match;
    logic [1:0]  a_out_length;
    logic [31:0] a_out_index;
    logic [15:0] a_match_count;

    // Instance B signals
    logic        b_in_valid = 1'b0, b_in_channel = 1'b0, b_out_ready = 1'b0;
    logic [15:0] b_in_data = '0;
    logic        b_in_ready, b_out_valid, b_out_match;
    logic [3:0]  b_out_length;
    logic [31:0] b_out_index;
    logic [15:0] b_match_count;

    hollywood_hash_search_core #(
        .WIDTH(16), .R4(16'h3412), .R6(16'h1234), .MAX_WORDS(2), .REPORT_ALL(1'b1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_channel(a_in_channel),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_match(a_out_match), .out_length(a_out_length), .out_index(a_out_index),
        .match_count(a_match_count)
    );

    hollywood_hash_search_core #(
        .WIDTH(16), .R4(16'h3412), .R6(16'h1234), .MAX_WORDS(8), .REPORT_ALL(1'b0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_channel(b_in_channel),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_match(b_out_match), .out_length(b_out_length), .out_index(b_out_index),
        .match_count(b_match_count)
    );

    // Behavioural model, one slot per instance.
    logic [15:0] m_r4 [2];
    logic [15:0] m_r6 [2];
    int          m_len [2];
    logic [31:0] m_idx [2];
    int          m_cnt [2];
    int          mw [2] = '{2, 8};
    bit          rep_all [2] = '{1'b1, 1'b0};

    function automatic logic [15:0] swap16(input logic [15:0] x);
        return 16'(((int'(x) << 8) | (int'(x) >> 8)) & 32'hFFFF);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_r4[d] = '0; m_r6[d] = '0; m_len[d] = 0; m_idx[d] = '0; m_cnt[d] = 0;
        end
    endtask

    task automatic drive_in(input int d, input logic v, input logic ch, input logic [15:0] data);
        if (d == 0) begin a_in_valid = v; a_in_channel = ch; a_in_data = data; end
        else        begin b_in_valid = v; b_in_channel = ch; b_in_data = data; end
    endtask

    function automatic logic get_ready(input int d);
        return (d == 0) ? a_in_ready : b_in_ready;
    endfunction
    function automatic logic get_ovalid(input int d);
        return (d == 0) ? a_out_valid : b_out_valid;
    endfunction
    function automatic logic get_match(input int d);
        return (d == 0) ? a_out_match : b_out_match;
    endfunction
    function automatic int get_len(input int d);
        return (d == 0) ? int'(a_out_length) : int'(b_out_length);
    endfunction
    function automatic logic [31:0] get_index(input int d);
        return (d == 0) ? a_out_index : b_out_index;
    endfunction
    function automatic logic [15:0] get_count(input int d);
        return (d == 0) ? a_match_count : b_match_count;
    endfunction

    // Check a result that must be presented now; hold backpressure for `hold`
    // cycles while offering an input beat that must be refused, then transfer.
    task automatic check_result(input int d, input logic em, input int el,
                                input logic [31:0] ei, input int hold);
        total++;
        if (get_ovalid(d) !== 1'b1) begin
            bad++; $display("FAIL dut%0d result_valid: got %b want 1", d, get_ovalid(d));
        end
        total++;
        if (get_match(d) !== em) begin
            bad++; $display("FAIL dut%0d out_match: got %b want %b", d, get_match(d), em);
        end
        total++;
        if (get_len(d) != el) begin
            bad++; $display("FAIL dut%0d out_length: got %0d want %0d", d, get_len(d), el);
        end
        total++;
        if (get_index(d) !== ei) begin
            bad++; $display("FAIL dut%0d out_index: got %0d want %0d", d, get_index(d), ei);
        end
        if (hold > 0) drive_in(d, 1'b1, 1'b0, 16'hFFFF);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            total++;
            if (get_ready(d) !== 1'b0 || get_ovalid(d) !== 1'b1 || get_match(d) !== em ||
                get_len(d) != el || get_index(d) !== ei) begin
                bad++;
                $display("FAIL dut%0d hold_stable cyc%0d: rdy=%b ov=%b m=%b l=%0d i=%0d want rdy=0 ov=1 m=%b l=%0d i=%0d",
                         d, c, get_ready(d), get_ovalid(d), get_match(d), get_len(d), get_index(d), em, el, ei);
            end
        end
        drive_in(d, 1'b0, 1'b0, 16'h0000);
        total++;
        if (get_count(d) !== 16'(m_cnt[d])) begin
            bad++; $display("FAIL dut%0d count_before: got %0d want %0d", d, get_count(d), m_cnt[d]);
        end
        if (d == 0) a_out_ready = 1'b1; else b_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (d == 0) a_out_ready = 1'b0; else b_out_ready = 1'b0;
        if (em && m_cnt[d] < 65535) m_cnt[d]++;
        total++;
        if (get_ovalid(d) !== 1'b0 || get_ready(d) !== 1'b1) begin
            bad++; $display("FAIL dut%0d after_xfer: ov=%b rdy=%b want ov=0 rdy=1", d, get_ovalid(d), get_ready(d));
        end
        total++;
        if (get_count(d) !== 16'(m_cnt[d])) begin
            bad++; $display("FAIL dut%0d match_count: got %0d want %0d", d, get_count(d), m_cnt[d]);
        end
    endtask

    // Offer one beat, wait (bounded) for acceptance, update model and check outcome.
    task automatic do_op(input int d, input logic ch, input logic [15:0] data, input int hold = 0);
        int n = 0;
        logic hit;
        int elen;
        logic [31:0] eidx;
        drive_in(d, 1'b1, ch, data);
        while (get_ready(d) !== 1'b1 && n < 50) begin
            @(negedge clk); n++;
        end
        if (get_ready(d) !== 1'b1) begin
            total++; bad++;
            $display("FAIL dut%0d accept_timeout: in_ready=%b want 1", d, get_ready(d));
            drive_in(d, 1'b0, 1'b0, 16'h0000);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        drive_in(d, 1'b0, 1'b0, 16'h0000);
        if (!ch) begin
            logic [15:0] s;
            logic [15:0] o4;
            s = swap16(data);
            o4 = m_r4[d];
            m_r4[d] = m_r6[d] ^ s;
            m_r6[d] = swap16(16'((int'(o4) + int'(s)) % 65536));
            m_len[d] = (m_len[d] + 1 > mw[d] + 1) ? mw[d] + 1 : m_len[d] + 1;
        end else if (data[0]) begin
            hit  = (m_r4[d] == 16'h3412) && (m_r6[d] == 16'h1234) && (m_len[d] <= mw[d]);
            elen = m_len[d];
            eidx = m_idx[d];
            m_idx[d] = m_idx[d] + 32'd1;
            m_r4[d] = '0; m_r6[d] = '0; m_len[d] = 0;
            if (hit || rep_all[d]) begin
                check_result(d, hit, elen, eidx, hold);
            end else begin
                total++;
                if (get_ovalid(d) !== 1'b0 || get_ready(d) !== 1'b1) begin
                    bad++; $display("FAIL dut%0d silent_eval: ov=%b rdy=%b want ov=0 rdy=1", d, get_ovalid(d), get_ready(d));
                end
            end
        end else begin
            m_r4[d] = '0; m_r6[d] = '0; m_len[d] = 0;
            total++;
            if (get_ovalid(d) !== 1'b0) begin
                bad++; $display("FAIL dut%0d clear_no_result: ov=%b want 0", d, get_ovalid(d));
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        total++;
        if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_out_match !== 1'b0 ||
            a_out_length !== 2'd0 || a_out_index !== 32'd0 || a_match_count !== 16'd0 ||
            b_in_ready !== 1'b0 || b_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: a rdy=%b ov=%b m=%b l=%0d i=%0d c=%0d b rdy=%b ov=%b want all 0",
                     a_in_ready, a_out_valid, a_out_match, a_out_length, a_out_index, a_match_count,
                     b_in_ready, b_out_valid);
        end
        reset_n = 1'b1;
        #1;
        total++;
        if (a_in_ready !== 1'b0) begin
            bad++; $display("FAIL ready_before_edge: got %b want 0", a_in_ready);
        end
        @(negedge clk);
        total++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            bad++; $display("FAIL ready_after_edge: a=%b b=%b want 1", a_in_ready, b_in_ready);
        end
    endtask

    task automatic test_directed();
        do_op(0, 1'b0, 16'h1234);
        do_op(0, 1'b1, 16'h0001);              // match, len 1, idx 0
        do_op(0, 1'b0, 16'h1234);
        do_op(0, 1'b0, 16'h0001);
        do_op(0, 1'b1, 16'h0001);              // no match, len 2, idx 1
        do_op(0, 1'b0, 16'h1234);
        do_op(0, 1'b1, 16'hFFFE);              // clear (bit0 = 0)
        do_op(0, 1'b0, 16'h1234);
        do_op(0, 1'b1, 16'h0001);              // match, len 1, idx 2
        for (int i = 0; i < 3; i++) do_op(0, 1'b0, 16'h1234);
        do_op(0, 1'b1, 16'h0001);              // over limit: len 3
        do_op(0, 1'b1, 16'h0001);              // empty candidate: zero state, no match
    endtask

    task automatic test_match_only();
        do_op(1, 1'b0, 16'hBEEF);
        do_op(1, 1'b1, 16'h0001);              // silent, index still advances
        do_op(1, 1'b1, 16'h0001);              // empty, silent
        do_op(1, 1'b0, 16'h1234);
        do_op(1, 1'b1, 16'h0003);              // match at idx 2
    endtask

    task automatic test_back_pressure();
        do_op(0, 1'b0, 16'h1234);
        do_op(0, 1'b1, 16'h0001, 5);
        do_op(0, 1'b0, 16'h1234);
        do_op(0, 1'b1, 16'h0001);              // refused beat must not leak in
    endtask

    task automatic test_random();
        for (int i = 0; i < 120; i++) begin
            int d;
            int r;
            logic [15:0] v;
            d = i % 2;
            r = int'($urandom_range(0, 99));
            v = ($urandom_range(0, 1) == 1) ? 16'h1234 : 16'($urandom);
            if (r < 10)      do_op(d, 1'b1, 16'($urandom) & 16'hFFFE);
            else if (r < 30) do_op(d, 1'b1, 16'($urandom) | 16'h0001, int'($urandom_range(0, 2)));
            else             do_op(d, 1'b0, v);
        end
    endtask

    task automatic test_reset_mid_report();
        do_op(0, 1'b0, 16'h1234);
        drive_in(0, 1'b1, 1'b1, 16'h0001);
        @(posedge clk);
        @(negedge clk);
        drive_in(0, 1'b0, 1'b0, 16'h0000);
        total++;
        if (a_out_valid !== 1'b1) begin
            bad++; $display("FAIL pre_reset_valid: got %b want 1", a_out_valid);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (a_out_valid !== 1'b0 || a_match_count !== 16'd0 || a_in_ready !== 1'b0) begin
            bad++; $display("FAIL async_reset: ov=%b cnt=%0d rdy=%b want 0 0 0", a_out_valid, a_match_count, a_in_ready);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_op(0, 1'b0, 16'h1234);
        do_op(0, 1'b1, 16'h0001);              // index restarts at 0
    endtask

    initial begin
        test_reset();
        test_directed();
        test_match_only();
        test_back_pressure();
        test_random();
        test_reset_mid_report();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
